// File: rtl/word_packer.sv
// word_packer: collects serial bits LSB-first into M-bit words and pushes each
// completed (or flushed, zero-padded) word into a downstream FIFO, stalling while
// the FIFO reports full. A wrapping counter tracks how many words were pushed.
module word_packer #(
  parameter int M  = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  input  logic          flush,
  input  logic          full,
  output logic          push,
  output logic [M-1:0]  word_out,
  output logic [CW-1:0] words_pushed,
  output logic          busy
);

  localparam int CNTW = $clog2(M);
  localparam logic [CNTW-1:0] LastIdx = CNTW'(M - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_nextCnt;
  logic [M-1:0]    r_acc;
  logic [M-1:0]    w_nextAcc;
  logic [M-1:0]    r_word;
  logic [M-1:0]    w_nextWord;
  logic [CW-1:0]   r_wordsPushed;
  logic [CW-1:0]   w_nextWordsPushed;

  logic            w_accept;
  logic [M-1:0]    w_packed;
  logic [M-1:0]    w_padded;
  logic [CNTW:0]   w_fill;

  assign bit_ready    = (r_state == COLLECT);
  assign push         = (r_state == EMIT) && !full;
  assign busy         = (r_state == EMIT) || (r_cnt != '0);
  assign word_out     = r_word;
  assign words_pushed = r_wordsPushed;

  assign w_accept = bit_valid && (r_state == COLLECT);
  assign w_fill   = {1'b0, r_cnt} + {{CNTW{1'b0}}, w_accept};

  // Merge this cycle's accepted bit into the accumulator and build the zero-padded flush view.
  always_comb begin
    w_packed = r_acc;
    if (w_accept) begin
      w_packed[r_cnt] = bit_in;
    end
    w_padded = '0;
    for (int k = 0; k < M; k++) begin
      if (k < int'(w_fill)) begin
        w_padded[k] = w_packed[k];
      end
    end
  end

  // Next-state logic: a completing bit wins over flush; the output word is only loaded on entry to EMIT.
  always_comb begin
    w_nextState       = r_state;
    w_nextCnt         = r_cnt;
    w_nextAcc         = r_acc;
    w_nextWord        = r_word;
    w_nextWordsPushed = r_wordsPushed;
    case (r_state)
      COLLECT: begin
        if (w_accept && (r_cnt == LastIdx)) begin
          w_nextWord  = w_packed;
          w_nextAcc   = '0;
          w_nextCnt   = '0;
          w_nextState = EMIT;
        end else if (flush && (w_fill != '0)) begin
          w_nextWord  = w_padded;
          w_nextAcc   = '0;
          w_nextCnt   = '0;
          w_nextState = EMIT;
        end else if (w_accept) begin
          w_nextAcc = w_packed;
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      EMIT: begin
        if (!full) begin
          w_nextState       = COLLECT;
          w_nextWordsPushed = r_wordsPushed + 1'b1;
        end
      end
      default: begin
        w_nextState = COLLECT;
      end
    endcase
  end

  // State register; an active-low reset discards any partial or pending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= COLLECT;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_word        <= '0;
      r_wordsPushed <= '0;
    end else begin
      r_state       <= w_nextState;
      r_cnt         <= w_nextCnt;
      r_acc         <= w_nextAcc;
      r_word        <= w_nextWord;
      r_wordsPushed <= w_nextWordsPushed;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Testbench for word_packer (M=2, CW=8): directed stimulus pushes expected words
// into a queue; a negedge monitor pops and compares on every push and tracks the
// pushed-word counter independently.
module tb_word_packer;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       flush;
  logic       full;
  logic       push;
  logic [1:0] word_out;
  logic [7:0] words_pushed;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] expQ[$];
  logic [7:0] monPushed = 8'd0;

  word_packer #(.M(2), .CW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .flush        (flush),
    .full         (full),
    .push         (push),
    .word_out     (word_out),
    .words_pushed (words_pushed),
    .busy         (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic f, input logic fu);
    bit_valid = v;
    bit_in    = b;
    flush     = f;
    full      = fu;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two bits b0 then b1 with full=0, then one idle cycle covering the push.
  task automatic sendWord(input logic b0, input logic b1, input logic [1:0] expWord);
    applyStimulus(1'b1, b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, b1, 1'b0, 1'b0);
    tick();
    expQ.push_back(expWord);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Scoreboard monitor: compares each pushed word and the running push count.
  always @(negedge clk) begin
    if (!reset) begin
      monPushed = 8'd0;
    end else begin
      checkOutput("words_pushed_track", 32'(words_pushed), 32'(monPushed));
      if (push) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_push: got word %0d, expected no push at time %0t", word_out, $time);
        end else begin
          checkOutput("pushed_word", 32'(word_out), 32'(expQ.pop_front()));
        end
        monPushed = monPushed + 8'd1;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    reset     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    flush     = 1'b0;
    full      = 1'b0;
    #2;
    checkOutput("reset_push", 32'(push), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(bit_ready), 32'd1);
    checkOutput("reset_count", 32'(words_pushed), 32'd0);
    checkOutput("reset_word", 32'(word_out), 32'd0);
    #20;
    reset = 1'b1;
    tick();

    // Bits 1,0 -> 2'b01 pushed the very next cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expQ.push_back(2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("r033_push", 32'(push), 32'd1);
    checkOutput("r033_ready", 32'(bit_ready), 32'd0);
    checkOutput("r033_word", 32'(word_out), 32'd1);
    tick();
    checkOutput("r033_push_after", 32'(push), 32'd0);
    checkOutput("r033_count", 32'(words_pushed), 32'd1);

    // Word 2'b11 stalled by full for three cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    expQ.push_back(2'b11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("r034_push_stall", 32'(push), 32'd0);
      checkOutput("r034_ready_stall", 32'(bit_ready), 32'd0);
      checkOutput("r034_word_hold", 32'(word_out), 32'd3);
      checkOutput("r034_count_hold", 32'(words_pushed), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("r034_push_release", 32'(push), 32'd1);
    tick();
    checkOutput("r034_count", 32'(words_pushed), 32'd2);
    checkOutput("r034_busy", 32'(busy), 32'd0);

    // One bit then flush alone -> 2'b01; flush with nothing held is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("r035_busy_partial", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expQ.push_back(2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("r035_push", 32'(push), 32'd1);
    checkOutput("r035_word", 32'(word_out), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("r035_empty_flush_push", 32'(push), 32'd0);
    checkOutput("r035_empty_flush_busy", 32'(busy), 32'd0);
    checkOutput("r035_count", 32'(words_pushed), 32'd3);

    // Completing bit together with flush: one word 2'b10, no extra padded word.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expQ.push_back(2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("r036_push", 32'(push), 32'd1);
    checkOutput("r036_word", 32'(word_out), 32'd2);
    tick();
    checkOutput("r036_no_extra", 32'(push), 32'd0);
    checkOutput("r036_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("r036_count", 32'(words_pushed), 32'd4);

    // Bit accepted with flush at cnt=0 -> padded word 2'b01.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expQ.push_back(2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_with_bit_push", 32'(push), 32'd1);
    checkOutput("flush_with_bit_word", 32'(word_out), 32'd1);
    tick();
    checkOutput("flush_with_bit_count", 32'(words_pushed), 32'd5);

    // Counter wrap: 250 more words reach 255, the next push wraps to 0.
    for (int i = 0; i < 250; i++) begin
      logic [1:0] pat;
      pat = 2'(i);
      sendWord(pat[0], pat[1], pat);
    end
    checkOutput("r037_count_255", 32'(words_pushed), 32'd255);
    sendWord(1'b1, 1'b1, 2'b11);
    checkOutput("r037_count_wrap", 32'(words_pushed), 32'd0);

    // Asynchronous reset during EMIT discards the word immediately.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("r038_push", 32'(push), 32'd0);
    checkOutput("r038_busy", 32'(busy), 32'd0);
    checkOutput("r038_count", 32'(words_pushed), 32'd0);
    checkOutput("r038_ready", 32'(bit_ready), 32'd1);
    checkOutput("r038_word", 32'(word_out), 32'd0);
    #5;
    reset = 1'b1;
    tick();
    sendWord(1'b0, 1'b1, 2'b10);
    checkOutput("r038_count_after", 32'(words_pushed), 32'd1);

    // Every expected word must have been consumed by the monitor.
    for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
      tick();
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
